// File: rtl/accel_op_arbiter_if.sv
// accel_op_arbiter_if
// Bundles the request, response and shared-unit signals of accel_op_arbiter.
//
// Parameters:
//   NREQ - number of requesters
//   IDW  - requester ID width, derived from NREQ
//
// Signals:
//   req_valid[NREQ]     per-requester request valid
//   req_op[5*NREQ]      per-requester opcode, slice i = [5*i+4:5*i]
//   req_data[19*NREQ]   per-requester operand, slice i = [19*i+18:19*i]
//   req_ready[NREQ]     one-hot grant/accept
//   rsp_valid/rsp_ready response handshake
//   rsp_id/rsp_data     requester index and captured result
//   rsp_err             illegal-opcode flag
//   alu_op/alu_b        opcode and operand to the shared unit
//   alu_start           single-cycle start pulse to the shared unit
//   alu_result          result from the shared unit
//   busy                arbiter is not idle
//
// Modports:
//   slave  - the arbiter side
//   master - the requester / unit / consumer side
interface accel_op_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
);
    logic [NREQ-1:0]    req_valid;
    logic [5*NREQ-1:0]  req_op;
    logic [19*NREQ-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [18:0]        rsp_data;
    logic               rsp_err;
    logic [4:0]         alu_op;
    logic [18:0]        alu_b;
    logic               alu_start;
    logic [18:0]        alu_result;
    logic               busy;

    modport slave (
        input  req_valid, req_op, req_data, rsp_ready, alu_result,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
               alu_op, alu_b, alu_start, busy
    );

    modport master (
        output req_valid, req_op, req_data, rsp_ready, alu_result,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
               alu_op, alu_b, alu_start, busy
    );
endinterface

// File: rtl/accel_op_arbiter.sv
// accel_op_arbiter
// Round-robin arbiter and sequencer sharing one 19-bit custom-instruction
// unit (FFT/ENC/DEC) among NREQ requesters. One request is accepted at a
// time, driven to the unit for LAT cycles, and the captured result is
// returned with the requester ID over a valid/ready response channel.
//
// Parameters:
//   NREQ - number of requesters (2..8)
//   LAT  - unit execution cycles before result capture (1..15)
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - accel_op_arbiter_if.slave (request, response and unit signals)
//
// Configuration macro:
//   ACCEL_OPCHECK_EN - when defined, an accepted illegal opcode bypasses the
//                      unit and is answered directly with rsp_err=1 and
//                      rsp_data=0. When undefined, every opcode runs through
//                      the unit and rsp_err is tied low.
module accel_op_arbiter #(
    parameter int NREQ = 4,
    parameter int LAT  = 2,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input logic               clk,
    input logic               rst_n,
    accel_op_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [IDW-1:0]  ptr;
    logic [3:0]      cnt;
    logic [IDW-1:0]  rsp_id_q;
    logic [18:0]     rsp_data_q;
    logic [4:0]      alu_op_q;
    logic [18:0]     alu_b_q;
    logic            alu_start_q;

    logic            found;
    logic [IDW-1:0]  winner;
    logic [NREQ-1:0] grant_vec;
    logic [4:0]      winner_op;
    logic [18:0]     winner_data;
    logic [IDW-1:0]  ptr_after;
    logic            accept;
    logic            skip_exec;

    // Rotating priority search: the first valid requester at or above ptr,
    // wrapping modulo NREQ, wins.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && bus.req_valid[idx]) begin
                found  = 1'b1;
                winner = IDW'(idx);
            end
        end
    end

    always_comb begin
        grant_vec = '0;
        if (state == IDLE && found) begin
            grant_vec[winner] = 1'b1;
        end
    end

    assign accept      = (state == IDLE) && found;
    assign winner_op   = bus.req_op[5*int'(winner) +: 5];
    assign winner_data = bus.req_data[19*int'(winner) +: 19];
    assign ptr_after   = (winner == IDW'(NREQ - 1)) ? '0 : winner + IDW'(1);

`ifdef ACCEL_OPCHECK_EN
    logic rsp_err_q;

    function automatic logic op_legal(input logic [4:0] op);
        return (op == 5'b10000) || (op == 5'b10001) || (op == 5'b10010);
    endfunction

    assign skip_exec   = !op_legal(winner_op);
    assign bus.rsp_err = rsp_err_q;
`else
    assign skip_exec   = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = skip_exec ? RESP : EXEC;
                end
            end
            EXEC: begin
                if (cnt == 4'd0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: request capture on accept, countdown while the unit runs,
    // result capture on the last EXEC cycle, opcode cleared on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr         <= '0;
            cnt         <= '0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            alu_op_q    <= 5'b00000;
            alu_b_q     <= '0;
            alu_start_q <= 1'b0;
`ifdef ACCEL_OPCHECK_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            alu_start_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        rsp_id_q <= winner;
                        ptr      <= ptr_after;
                        cnt      <= 4'(LAT - 1);
                        alu_b_q  <= winner_data;
                        if (skip_exec) begin
                            // The unit is never started for a rejected
                            // opcode, so its opcode input stays quiet.
                            alu_op_q   <= 5'b00000;
                            rsp_data_q <= '0;
`ifdef ACCEL_OPCHECK_EN
                            rsp_err_q  <= 1'b1;
`endif
                        end else begin
                            alu_op_q    <= winner_op;
                            alu_start_q <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    if (cnt == 4'd0) begin
                        rsp_data_q <= bus.alu_result;
`ifdef ACCEL_OPCHECK_EN
                        rsp_err_q  <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        alu_op_q <= 5'b00000;
                    end
                end
                default: begin
                    alu_op_q <= 5'b00000;
                end
            endcase
        end
    end

    assign bus.req_ready = grant_vec;
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_start = alu_start_q;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_accel_op_arbiter.sv
// tb_accel_op_arbiter
// Self-checking bench for accel_op_arbiter (NREQ=4, LAT=2). A stand-in for
// the shared unit computes FFT=b+1, ENC=b^19'h2AAAA, DEC=b^19'h2AAAA,
// anything else 0. A monitor predicts grants with its own round-robin
// pointer, pushes expected responses on accept and pops them on handshake.
// Honours ACCEL_OPCHECK_EN in the same way as the design.
module tb_accel_op_arbiter;

    localparam int NREQ    = 4;
    localparam int LAT     = 2;
    localparam int IDW     = 2;
    localparam int MAXWAIT = 200;

    localparam logic [4:0] OP_FFT = 5'b10000;
    localparam logic [4:0] OP_ENC = 5'b10001;
    localparam logic [4:0] OP_DEC = 5'b10010;

`ifdef ACCEL_OPCHECK_EN
    localparam bit OPCHECK = 1'b1;
`else
    localparam bit OPCHECK = 1'b0;
`endif

    typedef struct {
        logic [IDW-1:0] id;
        logic [18:0]    data;
        logic           err;
        int             acceptCycle;
        int             latency;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    accel_op_arbiter_if #(.NREQ(NREQ)) bus();

    accel_op_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    function automatic logic [18:0] unitModel(input logic [4:0] op, input logic [18:0] b);
        case (op)
            OP_FFT:  return b + 19'd1;
            OP_ENC:  return b ^ 19'h2AAAA;
            OP_DEC:  return b ^ 19'h2AAAA;
            default: return 19'd0;
        endcase
    endfunction

    function automatic logic skipsExec(input logic [4:0] op);
        return OPCHECK && !(op == OP_FFT || op == OP_ENC || op == OP_DEC);
    endfunction

    assign bus.alu_result = unitModel(bus.alu_op, bus.alu_b);

    int testsRun = 0;
    int testsFailed = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Monitor state
    exp_t           sb[$];
    int             grantLog[$];
    int             cycle = 0;
    int             modelPtr = 0;
    logic           modelIdle = 1'b1;
    logic           prevRspValid = 1'b0;
    int             lastAcceptCycle = -10;
    logic           lastStarts = 1'b0;
    int             startCount = 0;
    logic [IDW-1:0] lastRspId = '0;
    logic [18:0]    lastRspData = '0;
    logic           lastRspErr = 1'b0;
    int             mW;
    logic [4:0]     mOp;
    logic [18:0]    mData;
    exp_t           mEntry;

    always @(negedge clk) begin
        cycle++;
        if (!rst_n) begin
            sb.delete();
            modelPtr        = 0;
            modelIdle       = 1'b1;
            prevRspValid    = 1'b0;
            lastAcceptCycle = -10;
            lastStarts      = 1'b0;
        end else begin
            checkOutput("busy", 32'(bus.busy), 32'(!modelIdle));
            checkOutput("alu_start", 32'(bus.alu_start),
                        32'((cycle == lastAcceptCycle + 1) && lastStarts));
            if (bus.alu_start) startCount++;
            if (modelIdle) begin
                checkOutput("alu_op_idle", 32'(bus.alu_op), 32'd0);
                mW = -1;
                for (int k = 0; k < NREQ; k++) begin
                    if (mW < 0 && bus.req_valid[(modelPtr + k) % NREQ]) mW = (modelPtr + k) % NREQ;
                end
                if (mW < 0) begin
                    checkOutput("no_grant", 32'(bus.req_ready), 32'd0);
                end else begin
                    checkOutput("grant", 32'(bus.req_ready), 32'd1 << mW);
                    mOp   = bus.req_op[5*mW +: 5];
                    mData = bus.req_data[19*mW +: 19];
                    mEntry.id          = IDW'(mW);
                    mEntry.err         = skipsExec(mOp);
                    mEntry.data        = mEntry.err ? 19'd0 : unitModel(mOp, mData);
                    mEntry.acceptCycle = cycle;
                    mEntry.latency     = mEntry.err ? 1 : LAT + 1;
                    sb.push_back(mEntry);
                    grantLog.push_back(mW);
                    modelPtr        = (mW + 1) % NREQ;
                    modelIdle       = 1'b0;
                    lastAcceptCycle = cycle;
                    lastStarts      = !mEntry.err;
                end
            end else begin
                checkOutput("ready_busy", 32'(bus.req_ready), 32'd0);
            end
            if (bus.rsp_valid && !prevRspValid) begin
                if (sb.size() == 0) checkOutput("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
                else checkOutput("latency", 32'(cycle - sb[0].acceptCycle), 32'(sb[0].latency));
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
                end else begin
                    mEntry = sb.pop_front();
                    checkOutput("rsp_id", 32'(bus.rsp_id), 32'(mEntry.id));
                    checkOutput("rsp_data", 32'(bus.rsp_data), 32'(mEntry.data));
                    checkOutput("rsp_err", 32'(bus.rsp_err), 32'(mEntry.err));
                    lastRspId   = bus.rsp_id;
                    lastRspData = bus.rsp_data;
                    lastRspErr  = bus.rsp_err;
                    modelIdle   = 1'b1;
                end
            end
            prevRspValid = bus.rsp_valid;
        end
    end

    // All tasks start and end at posedge+1 so inputs never move at a negedge.
    task automatic waitGrant(input int id);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.req_ready[id] && n < MAXWAIT);
        checkOutput("grant_wait", 32'(bus.req_ready[id]), 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid[id] = 1'b0;
    endtask

    task automatic applyStimulus(input int id, input logic [4:0] op, input logic [18:0] data);
        bus.req_valid[id]         = 1'b1;
        bus.req_op[5*id +: 5]     = op;
        bus.req_data[19*id +: 19] = data;
        waitGrant(id);
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(modelIdle && sb.size() == 0) && n < MAXWAIT);
        checkOutput("idle_wait", 32'(modelIdle && sb.size() == 0), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int base;
        int n;
        int expGrants[6];
        expGrants = '{0, 1, 3, 0, 1, 3};

        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b1;

        // Reset values
        @(posedge clk);
        #1;
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("rst_alu_op", 32'(bus.alu_op), 32'd0);
        checkOutput("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single FFT from requester 2
        base = startCount;
        applyStimulus(2, OP_FFT, 19'h00002);
        waitIdle();
        checkOutput("t1_id", 32'(lastRspId), 32'd2);
        checkOutput("t1_data", 32'(lastRspData), 32'h00003);
        checkOutput("t1_err", 32'(lastRspErr), 32'd0);
        checkOutput("t1_starts", 32'(startCount - base), 32'd1);

        // Round robin among 0,1,3 holding ENC continuously
        applyReset();
        base = grantLog.size();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_op[5*i +: 5]     = OP_ENC;
            bus.req_data[19*i +: 19] = 19'h00003;
        end
        bus.req_valid = 4'b1011;
        n = 0;
        while (grantLog.size() < base + 6 && n < MAXWAIT) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        waitIdle();
        checkOutput("rr_count", 32'(grantLog.size() - base), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (base + i < grantLog.size())
                checkOutput("rr_order", 32'(grantLog[base + i]), 32'(expGrants[i]));
        end
        checkOutput("rr_data", 32'(lastRspData), 32'h2AAA9);

        // Wrap and decode
        applyStimulus(0, OP_FFT, 19'h7FFFF);
        waitIdle();
        checkOutput("fft_wrap", 32'(lastRspData), 32'h00000);
        applyStimulus(3, OP_DEC, 19'h2AAA9);
        waitIdle();
        checkOutput("dec", 32'(lastRspData), 32'h00003);

        // Response stall with another requester waiting
        bus.rsp_ready = 1'b0;
        applyStimulus(1, OP_ENC, 19'h12345);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.rsp_valid && n < MAXWAIT);
        @(posedge clk);
        #1;
        bus.req_op[10 +: 5]   = OP_FFT;
        bus.req_data[38 +: 19] = 19'h00005;
        bus.req_valid[2]      = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("stall_valid", 32'(bus.rsp_valid), 32'd1);
            checkOutput("stall_id", 32'(bus.rsp_id), 32'd1);
            checkOutput("stall_data", 32'(bus.rsp_data), 32'h389EF);
            checkOutput("stall_ready", 32'(bus.req_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("release_idle", 32'(bus.busy), 32'd0);
        checkOutput("release_grant", 32'(bus.req_ready), 32'b0100);
        @(posedge clk);
        #1;
        bus.req_valid[2] = 1'b0;
        waitIdle();

        // Illegal opcode
        applyStimulus(1, 5'b00000, 19'h01234);
        waitIdle();
        checkOutput("illegal_err", 32'(lastRspErr), 32'(OPCHECK));
        checkOutput("illegal_data", 32'(lastRspData), 32'd0);
        checkOutput("illegal_id", 32'(lastRspId), 32'd1);

        // Reset during EXEC
        applyStimulus(0, OP_FFT, 19'h00009);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_busy", 32'(bus.busy), 32'd0);
        checkOutput("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("arst_alu_start", 32'(bus.alu_start), 32'd0);
        checkOutput("arst_alu_op", 32'(bus.alu_op), 32'd0);
        checkOutput("arst_alu_b", 32'(bus.alu_b), 32'd0);
        checkOutput("arst_rsp_id", 32'(bus.rsp_id), 32'd0);
        checkOutput("arst_rsp_data", 32'(bus.rsp_data), 32'd0);
        checkOutput("arst_rsp_err", 32'(bus.rsp_err), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.req_op[0 +: 5]    = OP_FFT;
        bus.req_data[0 +: 19] = 19'h00001;
        bus.req_op[5 +: 5]    = OP_FFT;
        bus.req_data[19 +: 19] = 19'h00002;
        bus.req_valid         = 4'b0011;
        @(negedge clk);
        checkOutput("arst_first_grant", 32'(bus.req_ready), 32'b0001);
        @(posedge clk);
        #1;
        bus.req_valid[0] = 1'b0;
        waitGrant(1);
        waitIdle();
        checkOutput("arst_last_id", 32'(lastRspId), 32'd1);
        checkOutput("arst_last_data", 32'(lastRspData), 32'h00003);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
